bist_ctrl: RTL and testbench

March-style RAM BIST sequencer sitting directly downstream of the test pattern generator: it consumes the generator's current `word`, writes it to every RAM address, reads each address back and compares, then pulses `gen_next` to advance the generator to the next pattern. One completed run covers `Num_patterns` patterns and reports pass/fail to the test host.

---
 rtl/bist_ctrl.sv | 141 ++++++++++++++
 tb/tb_bist_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bist_ctrl.sv
// March-style RAM BIST sequencer: writes the generator's word to every address, reads back, compares, then advances the generator.
// Optional macro BIST_FAIL_LOG_EN keeps the first-fail address and the mismatch counter; without it both read as 0.
module bist_ctrl #(
    parameter int Word_size    = 3,
    parameter int Addr_size    = 4,
    parameter int Num_patterns = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [Word_size-1:0] word,
    output logic                 gen_next,
    output logic [Addr_size-1:0] ram_addr,
    output logic [Word_size-1:0] ram_wdata,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [Word_size-1:0] ram_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [Addr_size-1:0] fail_addr,
    output logic [7:0]           fail_count
);
    localparam int Pass_w = (Num_patterns > 1) ? $clog2(Num_patterns) : 1;
    localparam logic [Addr_size-1:0] Last_addr = '1;
    localparam logic [Pass_w-1:0]    Last_pass = Pass_w'(Num_patterns - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CMP, NEXT, NEXT_WAIT, DONE} state_t;

    state_t               state;
    logic [Addr_size-1:0] addr;
    logic [Pass_w-1:0]    pass;
    logic                 mismatch;

    assign mismatch = (ram_rdata != word);

    // Outputs are registered on the transition into the state that owns them,
    // so each one is valid for exactly the cycles the FSM sits in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            pass      <= '0;
            gen_next  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
`ifdef BIST_FAIL_LOG_EN
            fail_addr  <= '0;
            fail_count <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WRITE;
                        addr      <= '0;
                        pass      <= '0;
                        fail      <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= word;
`ifdef BIST_FAIL_LOG_EN
                        fail_addr  <= '0;
                        fail_count <= '0;
`endif
                    end
                end
                WRITE: begin
                    if (addr == Last_addr) begin
                        state     <= READ;
                        addr      <= '0;
                        ram_we    <= 1'b0;
                        ram_re    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                    end else begin
                        addr      <= addr + 1'b1;
                        ram_addr  <= addr + 1'b1;
                        ram_wdata <= word;
                    end
                end
                READ: begin
                    state    <= CMP;
                    ram_re   <= 1'b0;
                    ram_addr <= '0;
                end
                CMP: begin
                    if (mismatch) begin
                        fail <= 1'b1;
`ifdef BIST_FAIL_LOG_EN
                        if (!fail) fail_addr <= addr;
                        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
`endif
                    end
                    if (addr == Last_addr) begin
                        state    <= NEXT;
                        addr     <= '0;
                        gen_next <= 1'b1;
                    end else begin
                        state    <= READ;
                        addr     <= addr + 1'b1;
                        ram_re   <= 1'b1;
                        ram_addr <= addr + 1'b1;
                    end
                end
                NEXT: begin
                    state    <= NEXT_WAIT;
                    gen_next <= 1'b0;
                end
                NEXT_WAIT: begin
                    // The generator has advanced during this cycle, so word is already the new pattern.
                    if (pass == Last_pass) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= WRITE;
                        pass      <= pass + 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BIST_FAIL_LOG_EN
    assign fail_addr  = '0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: behavioural RAM with injectable faults and a 4-phase pattern generator.
module tb_bist_ctrl;
    localparam int W = 3;
    localparam int A = 4;
`ifdef BIST_FAIL_LOG_EN
    localparam bit Log_en = 1'b1;
`else
    localparam bit Log_en = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] word;
    logic         gen_next;
    logic [A-1:0] ram_addr;
    logic [W-1:0] ram_wdata;
    logic         ram_we;
    logic         ram_re;
    logic [W-1:0] ram_rdata = '0;
    logic         busy;
    logic         done;
    logic         fail;
    logic [A-1:0] fail_addr;
    logic [7:0]   fail_count;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;
    logic [1:0] gidx = 2'd0;
    logic       prev_gn = 1'b0;
    logic [W-1:0] seq [0:3];
    logic [W-1:0] mem [0:(1<<A)-1];

    bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word(word), .gen_next(gen_next),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        seq[0] = 3'b010; seq[1] = 3'b111; seq[2] = 3'b011; seq[3] = 3'b100;
    end

    // Pattern generator: free-running, no reset, advances on each gen_next pulse.
    assign word = seq[gidx];
    always @(posedge clk) if (gen_next) gidx <= gidx + 2'd1;

    function automatic logic [W-1:0] ram_read(input logic [A-1:0] a, input logic [W-1:0] d);
        if (fault_mode == 1 && a == 4'd5) return d & 3'b110;
        if (fault_mode == 2 && (a == 4'd3 || a == 4'd12)) return 3'b000;
        return d;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_read(ram_addr, mem[ram_addr]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("we_re_exclusive", 32'(ram_we & ram_re), 32'd0);
        check("gen_next_single", 32'(gen_next & prev_gn), 32'd0);
        if (ram_we) check("wdata_is_word", 32'(ram_wdata), 32'(word));
        else        check("wdata_idle", 32'(ram_wdata), 32'd0);
        if (!ram_we && !ram_re) check("addr_idle", 32'(ram_addr), 32'd0);
        prev_gn = gen_next;
    end

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("kick_busy", 32'(busy), 32'd1);
        check("kick_done", 32'(done), 32'd0);
        check("kick_fail", 32'(fail), 32'd0);
        check("kick_fail_count", 32'(fail_count), 32'd0);
        check("kick_we", 32'(ram_we), 32'd1);
    endtask

    task automatic run_to_done(input bit toggle, output int busy_cyc, output int gn_cyc);
        busy_cyc = 0;
        gn_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
            busy_cyc += int'(busy);
            gn_cyc += int'(gen_next);
            if (toggle) start = (busy_cyc < 190) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        check("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        int bc;
        int gc;
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int gc;
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_gen_next", 32'(gen_next), 32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free run
        kick();
        run_to_done(1'b0, bc, gc);
        check("clean_busy_cycles", 32'(bc), 32'd200);
        check("clean_gen_pulses", 32'(gc), 32'd4);
        check("clean_fail", 32'(fail), 32'd0);
        check("clean_fail_count", 32'(fail_count), 32'd0);
        check("clean_gen_phase", 32'(word), 32'b010);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);

        // Address 5 bit 0 stuck-at-0
        fault_mode = 1;
        kick();
        run_to_done(1'b0, bc, gc);
        check("sa0_fail", 32'(fail), 32'd1);
        check("sa0_fail_addr", 32'(fail_addr), Log_en ? 32'd5 : 32'd0);
        check("sa0_fail_count", 32'(fail_count), Log_en ? 32'd2 : 32'd0);
        check("sa0_busy_cycles", 32'(bc), 32'd200);

        // Addresses 3 and 12 stuck at 000, start toggled while busy
        fault_mode = 2;
        kick();
        run_to_done(1'b1, bc, gc);
        check("toggle_busy_cycles", 32'(bc), 32'd200);
        check("toggle_gen_pulses", 32'(gc), 32'd4);
        check("dual_fail", 32'(fail), 32'd1);
        check("dual_fail_addr", 32'(fail_addr), Log_en ? 32'd3 : 32'd0);
        check("dual_fail_count", 32'(fail_count), Log_en ? 32'd8 : 32'd0);

        // start held high in DONE restarts on the next edge with results cleared
        fault_mode = 0;
        kick();
        check("restart_fail_addr", 32'(fail_addr), 32'd0);
        run_to_done(1'b0, bc, gc);
        check("restart_busy_cycles", 32'(bc), 32'd200);
        check("restart_fail", 32'(fail), 32'd0);
        check("restart_gen_phase", 32'(word), 32'b010);

        // Reset during a READ of the second pass
        @(negedge clk);
        kick();
        gc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            gc += int'(gen_next);
            if (gc == 1 && ram_re) break;
        end
        check("reached_pass2_read", 32'(ram_re), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_re", 32'(ram_re), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_gen_next", 32'(gen_next), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick();
        run_to_done(1'b0, bc, gc);
        check("post_reset_busy_cycles", 32'(bc), 32'd200);
        check("post_reset_gen_pulses", 32'(gc), 32'd4);
        check("post_reset_fail", 32'(fail), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
